// File: rtl/mul4_share_arb_pkg.sv
// Shared defaults and controller state encoding for the two-requester
// multiplier arbiter.
package mul4_share_arb_pkg;

    localparam int W_DEF     = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/mul4_share_arb_mult.sv
// Signed 4x4 multiplier producing the exact 8-bit two's complement product.
module MultiplierSigned4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] y
);

    logic signed [7:0] a_ext;
    logic signed [7:0] b_ext;

    // Sign-extend first so -8 x -8 yields +64 rather than wrapping in 4 bits.
    assign a_ext = $signed({{4{a[3]}}, a});
    assign b_ext = $signed({{4{b[3]}}, b});
    assign y     = a_ext * b_ext;

endmodule

// File: rtl/mul4_share_arb.sv
// Round-robin arbiter sharing one signed 4x4 multiplier between two
// requesters, with a single registered result slot and a delivery counter.
module mul4_share_arb
    import mul4_share_arb_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [2*W-1:0]   out_y,
    output logic             out_id,
    input  logic             out_ready,
    output logic [CNT_W-1:0] done_cnt
);

    state_t             state_q, state_d;
    logic               prio_q, prio_d;
    logic [2*W-1:0]     y_q, y_d;
    logic               id_q, id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               slot_free;
    logic               drain;
    logic               grant0;
    logic               grant1;
    logic [W-1:0]       mul_a;
    logic [W-1:0]       mul_b;
    logic [2*W-1:0]     mul_y;

    MultiplierSigned4 u_mult (
        .a (mul_a),
        .b (mul_b),
        .y (mul_y)
    );

    // Grants are suppressed during reset so no operand pair is consumed
    // by a cycle whose result is about to be discarded.
    always_comb begin
        drain     = (state_q == ST_FULL) && out_ready;
        slot_free = (state_q == ST_EMPTY) || out_ready;
        grant0    = !rst && slot_free && req0_valid && (!req1_valid || !prio_q);
        grant1    = !rst && slot_free && req1_valid && (!req0_valid ||  prio_q);
        mul_a     = grant1 ? req1_a : req0_a;
        mul_b     = grant1 ? req1_b : req0_b;
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        y_d     = y_q;
        id_d    = id_q;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, drain};
        if (grant0 || grant1) begin
            state_d = ST_FULL;
            y_d     = mul_y;
            id_d    = grant1;
            prio_d  = grant0;
        end else if (drain) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            prio_q  <= 1'b0;
            y_q     <= '0;
            id_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            y_q     <= y_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign out_valid  = (state_q == ST_FULL);
    assign out_y      = y_q;
    assign out_id     = id_q;
    assign done_cnt   = cnt_q;

endmodule

// File: tb/tb_mul4_share_arb.sv
// Randomised and directed checking of mul4_share_arb against a behavioural
// model of the arbitration, product and delivery rules.
module tb_mul4_share_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0;
    logic [3:0] req0_a = '0;
    logic [3:0] req0_b = '0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [3:0] req1_a = '0;
    logic [3:0] req1_b = '0;
    logic       req1_ready;
    logic       out_valid;
    logic [7:0] out_y;
    logic       out_id;
    logic       out_ready = 1'b0;
    logic [7:0] done_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model of the observable state after the most recent edge.
    bit       m_valid = 0;
    bit [7:0] m_y     = 0;
    bit       m_id    = 0;
    bit [7:0] m_cnt   = 0;
    bit       m_prio  = 0;

    mul4_share_arb #(.W(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_y      (out_y),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .done_cnt   (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: evaluates the rules on the inputs the DUT will see at
    // the next rising edge, then advances the model across that edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                bit g0, g1, free;
                int pa, pb;
                g0 = 0;
                g1 = 0;
                free = !m_valid || out_ready;
                if (!rst && free) begin
                    if (req0_valid && req1_valid) begin
                        if (m_prio) g1 = 1; else g0 = 1;
                    end else if (req0_valid) g0 = 1;
                    else if (req1_valid) g1 = 1;
                end
                chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
                chk("out_y", {24'b0, out_y}, {24'b0, m_y});
                chk("out_id", {31'b0, out_id}, {31'b0, m_id});
                chk("done_cnt", {24'b0, done_cnt}, {24'b0, m_cnt});
                chk("req0_ready", {31'b0, req0_ready}, {31'b0, g0});
                chk("req1_ready", {31'b0, req1_ready}, {31'b0, g1});
                if (rst) begin
                    m_valid = 0; m_y = 0; m_id = 0; m_cnt = 0; m_prio = 0;
                end else begin
                    if (m_valid && out_ready) m_cnt = m_cnt + 8'd1;
                    if (g0 || g1) begin
                        pa = g1 ? int'($signed(req1_a)) : int'($signed(req0_a));
                        pb = g1 ? int'($signed(req1_b)) : int'($signed(req0_b));
                        m_y = 8'(pa * pb);
                        m_id = g1;
                        m_valid = 1;
                        m_prio = g0;
                    end else if (m_valid && out_ready) begin
                        m_valid = 0;
                    end
                end
            end
        end
    end

    task automatic drive(input bit r, input bit v0, input logic [3:0] a0, input logic [3:0] b0,
                         input bit v1, input logic [3:0] a1, input logic [3:0] b1, input bit ordy);
        @(posedge clk);
        #1;
        rst = r;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        out_ready = ordy;
    endtask

    task automatic at_sample();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input bit ordy);
        drive(0, 0, 4'h0, 4'h0, 0, 4'h0, 4'h0, ordy);
    endtask

    initial begin
        logic [7:0] c;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        drive(1, 0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0);
        at_sample();
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_done_cnt", {24'b0, done_cnt}, 32'd0);

        // -8 x -8 from requester 0
        drive(0, 1, 4'h8, 4'h8, 0, 4'h0, 4'h0, 1);
        idle(1);
        at_sample();
        chk("s1_y", {24'b0, out_y}, 32'h40);
        chk("s1_id", {31'b0, out_id}, 32'd0);
        chk("s1_valid", {31'b0, out_valid}, 32'd1);
        idle(1);
        at_sample();
        chk("s1_cnt", {24'b0, done_cnt}, 32'd1);
        chk("s1_drained", {31'b0, out_valid}, 32'd0);

        // Both valid from prio=0: req0 first, then req1
        drive(1, 0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0);
        drive(0, 1, 4'hC, 4'h9, 1, 4'h9, 4'hA, 1);
        at_sample();
        chk("s2_grant0", {30'b0, req1_ready, req0_ready}, 32'b01);
        drive(0, 1, 4'hC, 4'h9, 1, 4'h9, 4'hA, 1);
        at_sample();
        chk("s2_grant1", {30'b0, req1_ready, req0_ready}, 32'b10);
        chk("s2_first", {23'b0, out_id, out_y}, {23'b0, 1'b0, 8'h1C});
        drive(0, 1, 4'h1, 4'h1, 1, 4'h1, 4'h1, 1);
        at_sample();
        chk("s2_second", {23'b0, out_id, out_y}, {23'b0, 1'b1, 8'h2A});
        chk("s2_prio_back_to_0", {30'b0, req1_ready, req0_ready}, 32'b01);
        idle(1);
        idle(1);

        // Stall while holding -1 x -1 from requester 1
        drive(0, 0, 4'h0, 4'h0, 1, 4'hF, 4'hF, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 4'h3, 4'h3, 1, 4'h2, 4'h2, 0);
            at_sample();
            chk("s3_hold_y", {24'b0, out_y}, 32'h01);
            chk("s3_hold_id", {31'b0, out_id}, 32'd1);
            chk("s3_no_grant", {30'b0, req1_ready, req0_ready}, 32'b00);
        end
        c = done_cnt;
        idle(1);
        idle(1);
        at_sample();
        chk("s3_delivered", {31'b0, out_valid}, 32'd0);
        idle(1);
        at_sample();
        chk("s3_once", {24'b0, done_cnt}, {24'b0, 8'(c + 8'd1)});

        // Continuous contention alternates grants
        drive(1, 0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 4'($urandom), 4'($urandom), 1, 4'($urandom), 4'($urandom), 1);
            at_sample();
            chk("s4_alternate", {30'b0, req1_ready, req0_ready}, (i % 2 == 0) ? 32'b01 : 32'b10);
        end
        idle(1);
        idle(1);
        at_sample();
        chk("s4_cnt6", {24'b0, done_cnt}, 32'd6);

        // Reset discards a held result
        drive(0, 1, 4'h8, 4'h8, 0, 4'h0, 4'h0, 0);
        idle(0);
        at_sample();
        chk("s5_held", {23'b0, out_valid, out_y}, {23'b0, 1'b1, 8'h40});
        drive(1, 1, 4'h8, 4'h8, 1, 4'h1, 4'h1, 1);
        at_sample();
        chk("s5_rst_no_ready", {30'b0, req1_ready, req0_ready}, 32'b00);
        idle(0);
        at_sample();
        chk("s5_valid", {31'b0, out_valid}, 32'd0);
        chk("s5_cnt", {24'b0, done_cnt}, 32'd0);
        drive(0, 1, 4'h1, 4'h1, 1, 4'h1, 4'h1, 1);
        at_sample();
        chk("s5_prio0", {30'b0, req1_ready, req0_ready}, 32'b01);
        idle(1);
        idle(1);

        // Counter wrap after 256 deliveries
        drive(1, 0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0);
        for (int i = 0; i < 256; i++)
            drive(0, 1, 4'($urandom), 4'($urandom), 0, 4'h0, 4'h0, 1);
        idle(1);
        at_sample();
        chk("s6_cnt255", {24'b0, done_cnt}, 32'd255);
        idle(1);
        at_sample();
        chk("s6_wrap", {24'b0, done_cnt}, 32'd0);

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 63) == 0),
                  1'($urandom), 4'($urandom), 4'($urandom),
                  1'($urandom), 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) != 0));
        end
        idle(1);
        idle(1);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
